wb_arbiter_mc: RTL and testbench

Parametrised multi-channel writeback arbiter for the out-of-order issue core, replacing the fixed three-input writeback stage.
- Collects results from NUM_UNITS functional units (ALU/misc, memory, multiplier, future units), each through a private result FIFO of depth QDEPTH.
- Selects one result per cycle by round-robin and drives the single register-file write port.
- Provides per-channel backpressure and a pending-destination query for the issue-stage hazard logic.

---
 rtl/wb_arbiter_mc.sv | 212 +++++++++++++++++++++
 tb/tb_wb_arbiter_mc.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter_mc.sv
// ============================================================================
// Module      : wb_arbiter_mc
// Description : Multi-channel writeback arbiter. Each functional-unit result
//               channel feeds a private FIFO. One head entry per cycle is
//               picked round-robin and driven to the register-file write
//               port. Provides registered per-channel ready, a sticky
//               overflow flag and a pending-destination query.
//               Optional macro WB_BYPASS_EN lets an empty channel's incoming
//               result compete in the same cycle and skip its FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module wb_arbiter_mc #(
    parameter int NUM_UNITS = 3,
    parameter int QDEPTH    = 2,
    parameter int DATA_W    = 32,
    parameter int REG_AW    = 5
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [NUM_UNITS-1:0]          unit_wb_oper,
    input  logic [NUM_UNITS*REG_AW-1:0]   unit_wb_regdest,
    input  logic [NUM_UNITS-1:0]          unit_wb_writereg,
    input  logic [NUM_UNITS*DATA_W-1:0]   unit_wb_wbvalue,
    output logic [NUM_UNITS-1:0]          wb_unit_ready,
    output logic                          wb_reg_en,
    output logic [REG_AW-1:0]             wb_reg_addr,
    output logic [DATA_W-1:0]             wb_reg_data,
    input  logic [REG_AW-1:0]             query_addr,
    output logic                          query_pending,
    output logic                          wb_overflow
);

    localparam int PTR_W = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int RR_W  = (NUM_UNITS > 1) ? $clog2(NUM_UNITS) : 1;
    localparam logic [CNT_W-1:0] C_QDEPTH = CNT_W'(QDEPTH);

    // FIFO storage and control, one set per channel
    logic [REG_AW-1:0] addr_mem_q [NUM_UNITS][QDEPTH];
    logic [REG_AW-1:0] addr_mem_d [NUM_UNITS][QDEPTH];
    logic [DATA_W-1:0] data_mem_q [NUM_UNITS][QDEPTH];
    logic [DATA_W-1:0] data_mem_d [NUM_UNITS][QDEPTH];
    logic [QDEPTH-1:0] vld_q      [NUM_UNITS];
    logic [QDEPTH-1:0] vld_d      [NUM_UNITS];
    logic [PTR_W-1:0]  rd_ptr_q   [NUM_UNITS];
    logic [PTR_W-1:0]  rd_ptr_d   [NUM_UNITS];
    logic [PTR_W-1:0]  wr_ptr_q   [NUM_UNITS];
    logic [PTR_W-1:0]  wr_ptr_d   [NUM_UNITS];
    logic [CNT_W-1:0]  count_q    [NUM_UNITS];
    logic [CNT_W-1:0]  count_d    [NUM_UNITS];

    logic [RR_W-1:0]   rr_q, rr_d;
    logic              en_q, en_d;
    logic [REG_AW-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              ovf_q, ovf_d;

    logic [REG_AW-1:0]    w_dest [NUM_UNITS];
    logic [DATA_W-1:0]    w_val  [NUM_UNITS];
    logic [NUM_UNITS-1:0] w_writable;
    logic [NUM_UNITS-1:0] w_accept;
    logic [NUM_UNITS-1:0] w_cand;
    logic [NUM_UNITS-1:0] w_deq;
    logic [NUM_UNITS-1:0] w_byp;
    logic [NUM_UNITS-1:0] w_enq;
    logic                 w_win_vld;
    logic [RR_W-1:0]      w_win;
    logic                 w_hit;

    // Unpack channel buses; ready depends on registered occupancy only
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_dest[i]        = unit_wb_regdest[i*REG_AW +: REG_AW];
            w_val[i]         = unit_wb_wbvalue[i*DATA_W +: DATA_W];
            wb_unit_ready[i] = (count_q[i] < C_QDEPTH);
            w_writable[i]    = unit_wb_writereg[i] && (w_dest[i] != '0);
            w_accept[i]      = unit_wb_oper[i] && wb_unit_ready[i];
        end
    end

    // Arbitration candidates: non-empty FIFOs, plus empty-channel arrivals when bypass is built in
    always_comb begin
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_cand[i] = (count_q[i] != '0);
`ifdef WB_BYPASS_EN
            w_cand[i] = w_cand[i] || (w_accept[i] && w_writable[i]);
`endif
        end
    end

    // Round-robin scan: first candidate at or after the pointer, wrapping
    always_comb begin
        w_win_vld = 1'b0;
        w_win     = '0;
        for (int k = 0; k < NUM_UNITS; k++) begin
            if (!w_win_vld && w_cand[(int'(rr_q) + k) % NUM_UNITS]) begin
                w_win_vld = 1'b1;
                w_win     = RR_W'((int'(rr_q) + k) % NUM_UNITS);
            end
        end
    end

    // Per-channel dequeue / bypass / enqueue decisions
    always_comb begin
        w_deq = '0;
        w_byp = '0;
        w_enq = '0;
        for (int i = 0; i < NUM_UNITS; i++) begin
            w_deq[i] = w_win_vld && (w_win == RR_W'(i)) && (count_q[i] != '0);
`ifdef WB_BYPASS_EN
            w_byp[i] = w_win_vld && (w_win == RR_W'(i)) && (count_q[i] == '0);
`endif
            // Filtered results are accepted but never occupy a slot
            w_enq[i] = w_accept[i] && w_writable[i] && !w_byp[i];
        end
    end

    // Next-state for FIFOs, round-robin pointer, output register and overflow
    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        vld_d      = vld_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        rr_d       = rr_q;
        en_d       = w_win_vld;
        addr_d     = addr_q;
        data_d     = data_q;
        ovf_d      = ovf_q || ((unit_wb_oper & ~wb_unit_ready) != '0);

        if (w_win_vld) begin
            rr_d = (int'(w_win) == NUM_UNITS - 1) ? '0 : w_win + 1'b1;
        end

        for (int i = 0; i < NUM_UNITS; i++) begin
            if (w_deq[i]) begin
                addr_d                   = addr_mem_q[i][rd_ptr_q[i]];
                data_d                   = data_mem_q[i][rd_ptr_q[i]];
                vld_d[i][rd_ptr_q[i]]    = 1'b0;
                rd_ptr_d[i]              = rd_ptr_q[i] + 1'b1;
            end
            if (w_byp[i]) begin
                addr_d = w_dest[i];
                data_d = w_val[i];
            end
            if (w_enq[i]) begin
                addr_mem_d[i][wr_ptr_q[i]] = w_dest[i];
                data_mem_d[i][wr_ptr_q[i]] = w_val[i];
                vld_d[i][wr_ptr_q[i]]      = 1'b1;
                wr_ptr_d[i]                = wr_ptr_q[i] + 1'b1;
            end
            count_d[i] = count_q[i] + CNT_W'(w_enq[i]) - CNT_W'(w_deq[i]);
        end
    end

    // Control state with synchronous reset; flushes all buffered results
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_UNITS; i++) begin
                vld_q[i]    <= '0;
                rd_ptr_q[i] <= '0;
                wr_ptr_q[i] <= '0;
                count_q[i]  <= '0;
            end
            rr_q   <= '0;
            en_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
            ovf_q  <= 1'b0;
        end else begin
            vld_q    <= vld_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            rr_q     <= rr_d;
            en_q     <= en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ovf_q    <= ovf_d;
        end
    end

    // Payload storage needs no reset: entry validity lives in vld_q
    always_ff @(posedge clock) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    // Pending query: any valid buffered entry or the write now on the port
    always_comb begin
        w_hit = en_q && (addr_q == query_addr);
        for (int i = 0; i < NUM_UNITS; i++) begin
            for (int j = 0; j < QDEPTH; j++) begin
                if (vld_q[i][j] && (addr_mem_q[i][j] == query_addr)) begin
                    w_hit = 1'b1;
                end
            end
        end
        query_pending = w_hit && (query_addr != '0);
    end

    assign wb_reg_en   = en_q;
    assign wb_reg_addr = addr_q;
    assign wb_reg_data = data_q;
    assign wb_overflow = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_wb_arbiter_mc.sv
// ============================================================================
// Module      : tb_wb_arbiter_mc
// Description : Self-checking bench for wb_arbiter_mc (default build).
//               Queue-based reference model checked every cycle, a vector
//               table for idle/single-result/filtering, hand sequences for
//               contention, backpressure and mid-operation reset, then
//               randomized traffic.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_wb_arbiter_mc;

    localparam int NU = 3;
    localparam int QD = 2;
    localparam int DW = 32;
    localparam int AW = 5;

    logic            clock;
    logic            reset;
    logic [NU-1:0]   oper;
    logic [NU*AW-1:0] regdest;
    logic [NU-1:0]   writereg;
    logic [NU*DW-1:0] wbvalue;
    logic [NU-1:0]   ready;
    logic            reg_en;
    logic [AW-1:0]   reg_addr;
    logic [DW-1:0]   reg_data;
    logic [AW-1:0]   query_addr;
    logic            query_pending;
    logic            overflow;

    wb_arbiter_mc #(.NUM_UNITS(NU), .QDEPTH(QD), .DATA_W(DW), .REG_AW(AW)) dut (
        .clock            (clock),
        .reset            (reset),
        .unit_wb_oper     (oper),
        .unit_wb_regdest  (regdest),
        .unit_wb_writereg (writereg),
        .unit_wb_wbvalue  (wbvalue),
        .wb_unit_ready    (ready),
        .wb_reg_en        (reg_en),
        .wb_reg_addr      (reg_addr),
        .wb_reg_data      (reg_data),
        .query_addr       (query_addr),
        .query_pending    (query_pending),
        .wb_overflow      (overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, got, want, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } ent_t;
    ent_t          mq [NU][$];
    int            m_rr;
    logic          m_en;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_data;
    logic          m_ovf;

    function automatic logic [NU-1:0] m_ready();
        logic [NU-1:0] r;
        for (int i = 0; i < NU; i++) r[i] = (mq[i].size() < QD);
        return r;
    endfunction

    function automatic logic m_pend(input logic [AW-1:0] qa);
        logic hit;
        hit = m_en && (m_addr == qa);
        for (int i = 0; i < NU; i++)
            for (int j = 0; j < mq[i].size(); j++)
                if (mq[i][j].a == qa) hit = 1'b1;
        return hit && (qa != 0);
    endfunction

    task automatic model_step();
        logic [NU-1:0] rdy;
        int            w;
        ent_t          e;
        if (reset) begin
            for (int i = 0; i < NU; i++) mq[i].delete();
            m_rr = 0; m_en = 0; m_addr = 0; m_data = 0; m_ovf = 0;
            return;
        end
        rdy = m_ready();
        for (int i = 0; i < NU; i++) if (oper[i] && !rdy[i]) m_ovf = 1'b1;
        w = -1;
        for (int k = 0; k < NU; k++)
            if (w < 0 && mq[(m_rr + k) % NU].size() > 0) w = (m_rr + k) % NU;
        m_en = 1'b0;
        if (w >= 0) begin
            e      = mq[w].pop_front();
            m_en   = 1'b1;
            m_addr = e.a;
            m_data = e.d;
            m_rr   = (w + 1) % NU;
        end
        for (int i = 0; i < NU; i++) begin
            if (oper[i] && rdy[i] && writereg[i] && regdest[i*AW +: AW] != 0) begin
                e.a = regdest[i*AW +: AW];
                e.d = wbvalue[i*DW +: DW];
                mq[i].push_back(e);
            end
        end
    endtask

    // observed register-file writes (addresses)
    logic [AW-1:0] wlog [$];

    // One clock: inputs already driven at the negedge; step model, check after edge
    task automatic tick();
        model_step();
        @(posedge clock);
        #1;
        chk("wb_reg_en",     64'(reg_en),        64'(m_en));
        chk("wb_reg_addr",   64'(reg_addr),      64'(m_addr));
        chk("wb_reg_data",   64'(reg_data),      64'(m_data));
        chk("wb_unit_ready", 64'(ready),         64'(m_ready()));
        chk("wb_overflow",   64'(overflow),      64'(m_ovf));
        chk("query_pending", 64'(query_pending), 64'(m_pend(query_addr)));
        if (reg_en) wlog.push_back(reg_addr);
        @(negedge clock);
    endtask

    task automatic clear_in();
        oper = '0; regdest = '0; writereg = '0; wbvalue = '0;
    endtask

    task automatic set_ch(input int ch, input logic op, input logic wr,
                          input logic [AW-1:0] d, input logic [DW-1:0] v);
        oper[ch]              = op;
        writereg[ch]          = wr;
        regdest[ch*AW +: AW]  = d;
        wbvalue[ch*DW +: DW]  = v;
    endtask

    task automatic do_reset();
        clear_in();
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [NU-1:0] op;
        logic [NU-1:0] wr;
        logic [AW-1:0] dest;
        logic [DW-1:0] val;
        logic [AW-1:0] qa;
        logic          en;
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [NU-1:0] rdy;
        logic          pend;
    } vec_t;

    vec_t tbl [12];

    initial begin
        // idle after reset
        for (int r = 0; r < 5; r++)
            tbl[r] = '{3'b000, 3'b000, 5'd0, 32'h0, 5'd7, 1'b0, 5'd0, 32'h0, 3'b111, 1'b0};
        // single result on ch1 -> write two cycles later
        tbl[5]  = '{3'b010, 3'b010, 5'd5, 32'hDEADBEEF, 5'd5, 1'b0, 5'd0, 32'h0,        3'b111, 1'b1};
        tbl[6]  = '{3'b000, 3'b000, 5'd0, 32'h0,        5'd5, 1'b1, 5'd5, 32'hDEADBEEF, 3'b111, 1'b1};
        tbl[7]  = '{3'b000, 3'b000, 5'd0, 32'h0,        5'd5, 1'b0, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0};
        // filtering: writereg=0 on ch0, regdest=0 on ch1
        tbl[8]  = '{3'b001, 3'b000, 5'd9, 32'h1,        5'd9, 1'b0, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0};
        tbl[9]  = '{3'b010, 3'b010, 5'd0, 32'h2,        5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0};
        tbl[10] = '{3'b000, 3'b000, 5'd0, 32'h0,        5'd9, 1'b0, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0};
        tbl[11] = '{3'b000, 3'b000, 5'd0, 32'h0,        5'd0, 1'b0, 5'd5, 32'hDEADBEEF, 3'b111, 1'b0};

        reset = 1'b1;
        query_addr = '0;
        clear_in();
        for (int i = 0; i < NU; i++) mq[i].delete();
        m_rr = 0; m_en = 0; m_addr = 0; m_data = 0; m_ovf = 0;
        @(negedge clock);
        do_reset();

        for (int r = 0; r < 12; r++) begin
            for (int ch = 0; ch < NU; ch++)
                set_ch(ch, tbl[r].op[ch], tbl[r].wr[ch], tbl[r].dest, tbl[r].val);
            query_addr = tbl[r].qa;
            tick();
            chk($sformatf("vec%0d en", r),   64'(reg_en),        64'(tbl[r].en));
            chk($sformatf("vec%0d addr", r), 64'(reg_addr),      64'(tbl[r].addr));
            chk($sformatf("vec%0d data", r), 64'(reg_data),      64'(tbl[r].data));
            chk($sformatf("vec%0d rdy", r),  64'(ready),         64'(tbl[r].rdy));
            chk($sformatf("vec%0d pend", r), 64'(query_pending), 64'(tbl[r].pend));
            chk($sformatf("vec%0d ovf", r),  64'(overflow),      64'(0));
        end

        // ---------------- contention: two batches on all channels ----------------
        do_reset();
        wlog.delete();
        for (int ch = 0; ch < NU; ch++) set_ch(ch, 1'b1, 1'b1, AW'(ch + 1), DW'(32'h100 + ch));
        tick();
        for (int ch = 0; ch < NU; ch++) set_ch(ch, 1'b1, 1'b1, AW'(ch + 4), DW'(32'h200 + ch));
        tick();
        clear_in();
        for (int c = 0; c < 8; c++) tick();
        chk("contention count", 64'(wlog.size()), 64'(6));
        for (int k = 0; k < 6 && k < wlog.size(); k++)
            chk($sformatf("contention order %0d", k), 64'(wlog[k]), 64'(k + 1));

        // ---------------- backpressure: ch2 bursts 4, ch0 streams on ready ----------------
        do_reset();
        wlog.delete();
        for (int k = 0; k < 6; k++) begin
            clear_in();
            set_ch(0, ready[0], 1'b1, AW'(10 + k), DW'(32'h1000 + k));
            set_ch(2, (k < 4),  1'b1, AW'(20 + k), DW'(32'h2000 + k));
            tick();
            if (k == 1) chk("bp ready2 low", 64'(ready[2]), 64'(0));
        end
        clear_in();
        for (int c = 0; c < 8; c++) tick();
        chk("bp overflow", 64'(overflow), 64'(1));
        begin
            logic [AW-1:0] exp_bp [7];
            exp_bp = '{5'd10, 5'd20, 5'd11, 5'd21, 5'd12, 5'd23, 5'd14};
            chk("bp count", 64'(wlog.size()), 64'(7));
            for (int k = 0; k < 7 && k < wlog.size(); k++)
                chk($sformatf("bp order %0d", k), 64'(wlog[k]), 64'(exp_bp[k]));
        end

        // ---------------- reset mid-operation ----------------
        do_reset();
        for (int k = 0; k < 3; k++) begin
            for (int ch = 0; ch < NU; ch++) set_ch(ch, 1'b1, 1'b1, AW'(ch + 1), DW'(k));
            tick();
        end
        chk("mid ovf set", 64'(overflow), 64'(1));
        do_reset();
        wlog.delete();
        query_addr = 5'd1;
        for (int c = 0; c < 5; c++) begin
            tick();
            chk("mid en", 64'(reg_en), 64'(0));
            chk("mid rdy", 64'(ready), 64'(3'b111));
            chk("mid ovf", 64'(overflow), 64'(0));
            chk("mid pend", 64'(query_pending), 64'(0));
        end
        chk("mid writes", 64'(wlog.size()), 64'(0));

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 3000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            for (int ch = 0; ch < NU; ch++)
                set_ch(ch, ($urandom_range(0, 99) < 60), ($urandom_range(0, 9) != 0),
                       AW'($urandom_range(0, 7)), DW'($urandom));
            query_addr = AW'($urandom_range(0, 7));
            tick();
        end
        reset = 1'b0;
        clear_in();
        for (int c = 0; c < 6; c++) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
